// File: rtl/if_pc_sequencer.sv
// Fetch-side PC sequencer: owns the fetch PC, applies ID-resolved redirects and
// hazard stalls, and fills the IF/ID pipeline register with fetch statistics.
module if_pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DELAY_SLOT = 0,
    parameter logic [31:0] NOP        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] out_pc,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic        and_z_b,
    input  logic [31:0] branch_adder,
    input  logic [1:0]  Jmp,
    input  logic [25:0] jmp_addr,
    input  logic [31:0] address_on_reg,
    output logic [31:0] ifid_instruction,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        misalign_err,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
);

    localparam int CNT_FETCH = 0;
    localparam int CNT_STALL = 1;
    localparam int CNT_FLUSH = 2;
    localparam int NUM_CNT   = 3;

    logic [31:0] pc_reg, pc_next;
    logic [31:0] ins_reg, ins_next;
    logic [31:0] pc4_reg, pc4_next;
    logic        valid_reg, valid_next;
    logic        err_reg, err_next;

    logic [31:0] pc4;
    logic [31:0] target_raw;
    logic        redirect;
    logic [NUM_CNT-1:0] cnt_inc;
    logic [31:0] cnt_val [NUM_CNT];

    // Redirect decode; the ID-stage instruction only counts if it is valid.
    always_comb begin
        pc4        = pc_reg + 32'd4;
        target_raw = branch_adder;
        redirect   = 1'b0;
        case (Jmp)
            2'b10: begin
                target_raw = address_on_reg;
                redirect   = valid_reg;
            end
            2'b01: begin
                target_raw = {pc4_reg[31:28], jmp_addr, 2'b00};
                redirect   = valid_reg;
            end
            default: begin
                target_raw = branch_adder;
                redirect   = valid_reg & and_z_b;
            end
        endcase
    end

    always_comb begin
        pc_next    = pc_reg;
        ins_next   = ins_reg;
        pc4_next   = pc4_reg;
        valid_next = valid_reg;
        err_next   = err_reg;
        cnt_inc    = '0;
        if (stall) begin
            cnt_inc[CNT_STALL] = 1'b1;
        end else if (redirect) begin
            pc_next            = {target_raw[31:2], 2'b00};
            err_next           = err_reg | (target_raw[1:0] != 2'b00);
            pc4_next           = pc4;
            cnt_inc[CNT_FLUSH] = 1'b1;
            if (DELAY_SLOT != 0) begin
                ins_next           = instruction;
                valid_next         = 1'b1;
                cnt_inc[CNT_FETCH] = 1'b1;
            end else begin
                ins_next   = NOP;
                valid_next = 1'b0;
            end
        end else begin
            pc_next            = pc4;
            ins_next           = instruction;
            pc4_next           = pc4;
            valid_next         = 1'b1;
            cnt_inc[CNT_FETCH] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg    <= RESET_PC;
            ins_reg   <= NOP;
            pc4_reg   <= 32'd0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            pc_reg    <= pc_next;
            ins_reg   <= ins_next;
            pc4_reg   <= pc4_next;
            valid_reg <= valid_next;
            err_reg   <= err_next;
        end
    end

    // Statistics counters wrap silently at 2^32.
    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            logic [31:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= 32'd0;
                end else if (cnt_inc[gi]) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end
            assign cnt_val[gi] = cnt_reg;
        end
    endgenerate

    assign out_pc           = pc_reg;
    assign ifid_instruction = ins_reg;
    assign ifid_pc4         = pc4_reg;
    assign ifid_valid       = valid_reg;
    assign misalign_err     = err_reg;
    assign fetch_count      = cnt_val[CNT_FETCH];
    assign stall_count      = cnt_val[CNT_STALL];
    assign flush_count      = cnt_val[CNT_FLUSH];

endmodule

// File: tb/tb_if_pc_sequencer.sv
// Scoreboard bench for if_pc_sequencer: two instances (no delay slot / delay slot)
// share redirect stimulus; per-cycle model predictions are queued and popped after each edge.
module tb_if_pc_sequencer;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] pc4;
        logic        valid;
        logic        err;
        logic [31:0] fc;
        logic [31:0] sc;
        logic [31:0] flc;
    } st_t;

    localparam logic [31:0] NOPV = 32'h0000_0000;
    localparam logic [31:0] RPC  = 32'h0000_0000;

    logic        clk;
    logic        rst, stall, and_z_b;
    logic [31:0] branch_adder, address_on_reg;
    logic [1:0]  jmp;
    logic [25:0] jmp_addr;

    logic [31:0] pc0, ins_in0, ifi0, ifp0, fc0, sc0, flc0;
    logic        ifv0, err0;
    logic [31:0] pc1, ins_in1, ifi1, ifp1, fc1, sc1, flc1;
    logic        ifv1, err1;

    int total = 0;
    int bad   = 0;
    st_t m0, m1;
    st_t q0[$];
    st_t q1[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign ins_in0 = imem(pc0);
    assign ins_in1 = imem(pc1);

    if_pc_sequencer #(.RESET_PC(RPC), .DELAY_SLOT(0), .NOP(NOPV)) dut0 (
        .clk(clk), .rst(rst), .out_pc(pc0), .instruction(ins_in0), .stall(stall),
        .and_z_b(and_z_b), .branch_adder(branch_adder), .Jmp(jmp), .jmp_addr(jmp_addr),
        .address_on_reg(address_on_reg), .ifid_instruction(ifi0), .ifid_pc4(ifp0),
        .ifid_valid(ifv0), .misalign_err(err0), .fetch_count(fc0), .stall_count(sc0),
        .flush_count(flc0)
    );

    if_pc_sequencer #(.RESET_PC(RPC), .DELAY_SLOT(1), .NOP(NOPV)) dut1 (
        .clk(clk), .rst(rst), .out_pc(pc1), .instruction(ins_in1), .stall(stall),
        .and_z_b(and_z_b), .branch_adder(branch_adder), .Jmp(jmp), .jmp_addr(jmp_addr),
        .address_on_reg(address_on_reg), .ifid_instruction(ifi1), .ifid_pc4(ifp1),
        .ifid_valid(ifv1), .misalign_err(err1), .fetch_count(fc1), .stall_count(sc1),
        .flush_count(flc1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference behaviour of one sequencer for one clock edge.
    function automatic st_t step(input st_t s, input bit ds);
        st_t n;
        logic [31:0] seq_pc, tgt;
        bit take;
        n = s;
        seq_pc = s.pc + 32'd4;
        if (rst) begin
            n.pc = RPC; n.ins = NOPV; n.pc4 = '0; n.valid = 1'b0; n.err = 1'b0;
            n.fc = '0; n.sc = '0; n.flc = '0;
            return n;
        end
        if (stall) begin
            n.sc = s.sc + 1;
            return n;
        end
        take = 1'b0;
        tgt  = '0;
        if (s.valid) begin
            if (jmp == 2'b10) begin
                take = 1'b1; tgt = address_on_reg;
            end else if (jmp == 2'b01) begin
                take = 1'b1; tgt = {s.pc4[31:28], jmp_addr, 2'b00};
            end else if (and_z_b) begin
                take = 1'b1; tgt = branch_adder;
            end
        end
        n.pc4 = seq_pc;
        if (take) begin
            n.pc  = tgt & 32'hFFFF_FFFC;
            n.err = s.err | (tgt[1:0] != 2'b00);
            n.flc = s.flc + 1;
            n.ins   = ds ? imem(s.pc) : NOPV;
            n.valid = ds;
            if (ds) n.fc = s.fc + 1;
        end else begin
            n.pc    = seq_pc;
            n.ins   = imem(s.pc);
            n.valid = 1'b1;
            n.fc    = s.fc + 1;
        end
        return n;
    endfunction

    task automatic cmp_state(input string who, input st_t got, input st_t e);
        chk({who, ".pc"},    got.pc,    e.pc);
        chk({who, ".ins"},   got.ins,   e.ins);
        chk({who, ".pc4"},   got.pc4,   e.pc4);
        chk({who, ".valid"}, {31'd0, got.valid}, {31'd0, e.valid});
        chk({who, ".err"},   {31'd0, got.err},   {31'd0, e.err});
        chk({who, ".fetch"}, got.fc,    e.fc);
        chk({who, ".stall"}, got.sc,    e.sc);
        chk({who, ".flush"}, got.flc,   e.flc);
    endtask

    task automatic cyc();
        st_t g0, g1;
        q0.push_back(step(m0, 1'b0));
        q1.push_back(step(m1, 1'b1));
        @(posedge clk);
        #1;
        m0 = q0.pop_front();
        m1 = q1.pop_front();
        g0 = '{pc:pc0, ins:ifi0, pc4:ifp0, valid:ifv0, err:err0, fc:fc0, sc:sc0, flc:flc0};
        g1 = '{pc:pc1, ins:ifi1, pc4:ifp1, valid:ifv1, err:err1, fc:fc1, sc:sc1, flc:flc1};
        cmp_state("ds0", g0, m0);
        cmp_state("ds1", g1, m1);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; and_z_b = 1'b0; jmp = 2'b00;
        branch_adder = '0; address_on_reg = '0; jmp_addr = '0;
        m0 = '0; m1 = '0;

        cyc();
        chk("rst_valid", {31'd0, ifv0}, 32'd0);
        cyc();
        chk("rst_pc", pc0, RPC);
        chk("rst_ins", ifi0, NOPV);
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk($sformatf("seq_pc%0d", i), pc0, 32'(i * 4));
            if (i == 1) begin
                chk("first_ins", ifi0, imem(32'h0));
                chk("first_pc4", ifp0, 32'h4);
                chk("first_valid", {31'd0, ifv0}, 32'd1);
            end
        end
        chk("fetch4", fc0, 32'd4);

        // taken branch
        and_z_b = 1'b1; branch_adder = 32'h40;
        cyc();
        and_z_b = 1'b0;
        chk("br_pc", pc0, 32'h40);
        chk("br_nop", ifi0, NOPV);
        chk("br_valid", {31'd0, ifv0}, 32'd0);
        chk("br_flush", flc0, 32'd1);
        chk("ds_valid", {31'd0, ifv1}, 32'd1);
        chk("ds_ins", ifi1, imem(32'h10));
        cyc();
        chk("tgt_ins", ifi0, imem(32'h40));
        chk("tgt_pc4", ifp0, 32'h44);

        // jump beats branch; upper bits from the jump's own PC+4
        jmp = 2'b10; address_on_reg = 32'h1000_0004;
        cyc();
        jmp = 2'b00;
        cyc();
        chk("jset_pc4", ifp0, 32'h1000_0008);
        jmp = 2'b01; jmp_addr = 26'h000_0010; and_z_b = 1'b1; branch_adder = 32'h40;
        cyc();
        jmp = 2'b00; and_z_b = 1'b0;
        chk("j_pc", pc0, 32'h1000_0040);
        chk("j_pc_ds", pc1, 32'h1000_0040);
        cyc();
        jmp = 2'b10; address_on_reg = 32'h200;
        cyc();
        jmp = 2'b00;
        chk("jr_pc", pc0, 32'h200);
        cyc();

        // stall with a branch presented
        stall = 1'b1; and_z_b = 1'b1; branch_adder = 32'h80;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_pc", pc0, 32'h204);
            chk("stall_ins", ifi0, imem(32'h200));
        end
        chk("stall_cnt", sc0, 32'd3);
        chk("stall_flush", flc0, 32'd4);
        stall = 1'b0;
        cyc();
        and_z_b = 1'b0;
        chk("rel_pc", pc0, 32'h80);
        chk("rel_flush", flc0, 32'd5);
        cyc();

        // misaligned register target, then wrap
        jmp = 2'b10; address_on_reg = 32'h0000_0103;
        cyc();
        jmp = 2'b00;
        chk("mis_pc", pc0, 32'h100);
        chk("mis_err", {31'd0, err0}, 32'd1);
        cyc();
        cyc();
        chk("mis_sticky", {31'd0, err0}, 32'd1);
        jmp = 2'b10; address_on_reg = 32'hFFFF_FFFC;
        cyc();
        jmp = 2'b00;
        chk("top_pc", pc0, 32'hFFFF_FFFC);
        cyc();
        chk("wrap_pc", pc0, 32'h0);

        // random traffic
        for (int i = 0; i < 60; i++) begin
            stall          = ($urandom_range(0, 3) == 0);
            and_z_b        = $urandom_range(0, 1) == 1;
            jmp            = 2'($urandom_range(0, 3));
            branch_adder   = $urandom & (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            address_on_reg = $urandom & 32'hFFFF_FFFC;
            jmp_addr       = 26'($urandom);
            cyc();
        end

        // reset on the same cycle as a redirect
        stall = 1'b0; jmp = 2'b10; address_on_reg = 32'h300; and_z_b = 1'b1; rst = 1'b1;
        cyc();
        chk("mr_pc", pc0, RPC);
        chk("mr_fetch", fc0, 32'd0);
        chk("mr_stall", sc0, 32'd0);
        chk("mr_flush", flc0, 32'd0);
        chk("mr_pc_ds", pc1, RPC);
        chk("mr_err_ds", {31'd0, err1}, 32'd0);
        rst = 1'b0; jmp = 2'b00; and_z_b = 1'b0;
        cyc();
        cyc();
        chk("post_pc", pc0, 32'h8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
